// File: rtl/frogger_pkg.sv
// Shared keyboard definitions for the Frogger input front-end.
// Build option: define FROG_INPUT_WASD_EN to also decode W/A/S/D as directions.
package frogger_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    // One key slot to a direction; a slot holds a single code, so arrows
    // and WASD never compete inside the same slot.
    function automatic dir_t key_to_dir(input logic [7:0] code);
        dir_t d;
        case (code)
            KEY_UP:    d = DIR_UP;
            KEY_DOWN:  d = DIR_DOWN;
            KEY_LEFT:  d = DIR_LEFT;
            KEY_RIGHT: d = DIR_RIGHT;
`ifdef FROG_INPUT_WASD_EN
            KEY_W:     d = DIR_UP;
            KEY_S:     d = DIR_DOWN;
            KEY_A:     d = DIR_LEFT;
            KEY_D:     d = DIR_RIGHT;
`endif
            default:   d = DIR_NONE;
        endcase
        return d;
    endfunction

    // LED layout {left,up,down,right}
    function automatic logic [3:0] dir_to_led(input dir_t d);
        logic [3:0] led;
        case (d)
            DIR_LEFT:  led = 4'b1000;
            DIR_UP:    led = 4'b0100;
            DIR_DOWN:  led = 4'b0010;
            DIR_RIGHT: led = 4'b0001;
            default:   led = 4'b0000;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the VGA vsync into the Clk domain and emits a one-cycle tick per
// frame, three Clk edges after the frame_clk rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic [2:0] sync_q;

    // two synchroniser flops, one history flop, registered edge detect
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
            tick   <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/frog_input_ctrl.sv
// Keyboard front-end: persistent frog selection plus frame-aligned move
// strobes with hold-to-repeat. WASD decoding is enabled by defining
// FROG_INPUT_WASD_EN (handled in frogger_pkg::key_to_dir).
module frog_input_ctrl
    import frogger_pkg::*;
#(
    parameter int         NUM_FROGS    = 3,
    parameter logic [7:0] SEL_KEY_BASE = 8'h59,
    parameter int         REPEAT_DELAY = 15,
    parameter int         REPEAT_RATE  = 4,
    localparam int        IW = (NUM_FROGS > 1) ? $clog2(NUM_FROGS) : 1,
    localparam int        CW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [15:0]          keycode,
    input  logic                 frame_clk,
    input  logic [NUM_FROGS-1:0] frog_alive,
    input  logic                 game_over,
    output logic [NUM_FROGS-1:0] sel_onehot,
    output logic [IW-1:0]        sel_idx,
    output logic                 sel_valid,
    output logic                 up,
    output logic                 down,
    output logic                 left,
    output logic                 right,
    output logic [3:0]           last_dir
);

    localparam logic [CW-1:0] CNT_DELAY = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] CNT_RATE  = CW'(REPEAT_RATE - 1);

    logic tick;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    logic [15:0] kc_q;
    dir_t        dir_s0, key_dir;

    // keycode is registered once; all decode works off the registered copy
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) kc_q <= '0;
        else       kc_q <= keycode;
    end

    assign dir_s0  = key_to_dir(kc_q[7:0]);
    assign key_dir = (dir_s0 != DIR_NONE) ? dir_s0 : key_to_dir(kc_q[15:8]);

    // ---------------- selection ----------------
    logic          sel_valid_q, sel_valid_n, sel_hit, sel_chg;
    logic [IW-1:0] sel_idx_q, sel_idx_n, hit_idx, wrap_idx, cand;

    // select-key hit (slot0 scanned last so it wins), and next alive frog
    // above the current one in cyclic order for when the current one dies
    always_comb begin
        sel_hit  = 1'b0;
        hit_idx  = '0;
        wrap_idx = sel_idx_q;
        cand     = '0;
        for (int k = 0; k < NUM_FROGS; k++)
            if (kc_q[15:8] == 8'(SEL_KEY_BASE + k) && frog_alive[IW'(k)]) begin
                sel_hit = 1'b1;
                hit_idx = IW'(k);
            end
        for (int k = 0; k < NUM_FROGS; k++)
            if (kc_q[7:0] == 8'(SEL_KEY_BASE + k) && frog_alive[IW'(k)]) begin
                sel_hit = 1'b1;
                hit_idx = IW'(k);
            end
        // descending offsets so the nearest alive frog is written last
        for (int i = NUM_FROGS; i >= 1; i--) begin
            cand = IW'((int'(sel_idx_q) + i) % NUM_FROGS);
            if (frog_alive[cand]) wrap_idx = cand;
        end
    end

    // next selection; everything is frozen while the game is over
    always_comb begin
        sel_idx_n   = sel_idx_q;
        sel_valid_n = sel_valid_q;
        if (!game_over) begin
            if (sel_hit) begin
                sel_idx_n   = hit_idx;
                sel_valid_n = 1'b1;
            end else if (frog_alive == '0) begin
                sel_valid_n = 1'b0;
            end else if (!sel_valid_q || !frog_alive[sel_idx_q]) begin
                sel_idx_n   = frog_alive[sel_idx_q] ? sel_idx_q : wrap_idx;
                sel_valid_n = 1'b1;
            end
        end
        sel_chg = (sel_idx_n != sel_idx_q) || (sel_valid_n != sel_valid_q);
    end

    // selection register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sel_idx_q   <= '0;
            sel_valid_q <= 1'b1;
        end else begin
            sel_idx_q   <= sel_idx_n;
            sel_valid_q <= sel_valid_n;
        end
    end

    // ---------------- repeat FSM ----------------
    rpt_state_t    state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    dir_t          held_q, held_n, strb_q;
    logic [3:0]    last_dir_q;
    logic          issue;

    // state register plus the strobe/last_dir registers it drives
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            held_q     <= DIR_NONE;
            strb_q     <= DIR_NONE;
            last_dir_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            held_q  <= held_n;
            if (game_over)  strb_q <= DIR_NONE;
            else if (tick)  strb_q <= issue ? key_dir : DIR_NONE;
            if (issue)      last_dir_q <= dir_to_led(key_dir);
        end
    end

    // next state: game over or a new frog aborts any held key immediately,
    // otherwise the FSM only moves on the frame tick
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        held_n  = held_q;
        issue   = 1'b0;
        if (game_over || sel_chg) begin
            state_n = IDLE;
        end else if (tick) begin
            case (state_q)
                IDLE: if (key_dir != DIR_NONE && sel_valid_q) begin
                    issue   = 1'b1;
                    held_n  = key_dir;
                    cnt_n   = CNT_DELAY;
                    state_n = DELAY;
                end
                DELAY, REPEAT: begin
                    if (key_dir == DIR_NONE) begin
                        state_n = IDLE;
                    end else if (key_dir != held_q) begin
                        issue   = 1'b1;
                        held_n  = key_dir;
                        cnt_n   = CNT_DELAY;
                        state_n = DELAY;
                    end else if (cnt_q == '0) begin
                        issue   = 1'b1;
                        cnt_n   = CNT_RATE;
                        state_n = REPEAT;
                    end else begin
                        cnt_n = cnt_q - CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // outputs decoded from registered state
    always_comb begin
        up         = (strb_q == DIR_UP);
        down       = (strb_q == DIR_DOWN);
        left       = (strb_q == DIR_LEFT);
        right      = (strb_q == DIR_RIGHT);
        sel_onehot = '0;
        if (sel_valid_q) sel_onehot[sel_idx_q] = 1'b1;
    end

    assign sel_idx   = sel_idx_q;
    assign sel_valid = sel_valid_q;
    assign last_dir  = last_dir_q;

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Self-checking bench for frog_input_ctrl: table of single-press decodes,
// hand sequences for repeat timing, selection and game-over, then a
// randomized run against a frame-level behavioural model.
module tb_frog_input_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, frame_clk, game_over;
    logic [15:0] keycode;
    logic [2:0]  frog_alive, sel_onehot;
    logic [1:0]  sel_idx;
    logic        sel_valid, up, down, left, right;
    logic [3:0]  last_dir;
    wire  [3:0]  dirs = {left, up, down, right};

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    frog_input_ctrl #(
        .NUM_FROGS(3), .SEL_KEY_BASE(8'h59), .REPEAT_DELAY(15), .REPEAT_RATE(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
        .frog_alive(frog_alive), .game_over(game_over), .sel_onehot(sel_onehot),
        .sel_idx(sel_idx), .sel_valid(sel_valid), .up(up), .down(down),
        .left(left), .right(right), .last_dir(last_dir)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // raise vsync and wait until the strobe for that frame has settled
    task automatic frame_start();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
    endtask

    task automatic frame_end();
        frame_clk = 1'b0;
        repeat (13) @(negedge Clk);
    endtask

    task automatic idle_frame();
        keycode = 16'h0000;
        frame_start();
        frame_end();
    endtask

    // reference decode {left,up,down,right}
    function automatic logic [3:0] m_dir(input logic [7:0] c);
        case (c)
            8'h52: return 4'b0100;
            8'h51: return 4'b0010;
            8'h50: return 4'b1000;
            8'h4F: return 4'b0001;
`ifdef FROG_INPUT_WASD_EN
            8'h1A: return 4'b0100;
            8'h16: return 4'b0010;
            8'h04: return 4'b1000;
            8'h07: return 4'b0001;
`endif
            default: return 4'b0000;
        endcase
    endfunction

    typedef struct {
        logic [15:0] kc;
        logic [3:0]  exp;
    } vec_t;
    vec_t tbl [10];

    // frame-level model state: direction held since which frame
    logic [7:0]  codes [9];
    logic [15:0] kc;
    logic [3:0]  m_held, m_last, d, exp_d;
    logic        m_active;
    int          m_age, m_idx, ksel;

    initial begin
        tbl[0] = '{16'h0052, 4'b0100};
        tbl[1] = '{16'h0051, 4'b0010};
        tbl[2] = '{16'h0050, 4'b1000};
        tbl[3] = '{16'h004F, 4'b0001};
        tbl[4] = '{16'h5200, 4'b0100};
        tbl[5] = '{16'h5150, 4'b1000};
        tbl[6] = '{16'h0000, 4'b0000};
        tbl[7] = '{16'h005F, 4'b0000};
        tbl[8] = '{16'h0059, 4'b0000};
`ifdef FROG_INPUT_WASD_EN
        tbl[9] = '{16'h001A, 4'b0100};
`else
        tbl[9] = '{16'h001A, 4'b0000};
`endif
        codes = '{8'h00, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h59, 8'h5A, 8'h5B, 8'h5F};

        Reset = 1'b1; keycode = '0; frame_clk = 1'b0; frog_alive = 3'b111; game_over = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_onehot", sel_onehot, 3'b001);
        check("rst_idx", sel_idx, 0);
        check("rst_valid", sel_valid, 1);
        check("rst_dirs", dirs, 0);
        check("rst_last", last_dir, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        idle_frame();

        // single up press
        keycode = 16'h0052;
        frame_start();
        check("up_strobe", dirs, 4'b0100);
        check("up_last", last_dir, 4'b0100);
        check("up_idx", sel_idx, 0);
        frame_end();
        keycode = 16'h0000;
        frame_start();
        check("up_one_frame", dirs, 0);
        frame_end();

        // decode table, each press from idle
        for (int i = 0; i < 10; i++) begin
            keycode = tbl[i].kc;
            frame_start();
            check($sformatf("tbl%0d", i), dirs, tbl[i].exp);
            frame_end();
            idle_frame();
        end

        // hold right: moves at 0, 15, 19, 23, 27
        keycode = 16'h004F;
        for (int f = 0; f < 30; f++) begin
            frame_start();
            check($sformatf("hold_right_f%0d", f), dirs,
                  (f == 0 || f == 15 || f == 19 || f == 23 || f == 27) ? 4'b0001 : 4'b0000);
            frame_end();
        end
        idle_frame();

        // selection keys
        keycode = 16'h005A;
        repeat (2) @(negedge Clk);
        check("sel_key_2clk", sel_onehot, 3'b010);
        keycode = 16'h005F;
        repeat (3) @(negedge Clk);
        check("sel_out_of_range", sel_onehot, 3'b010);
        keycode = 16'h0000;
        repeat (3) @(negedge Clk);
        check("sel_persist", sel_idx, 1);
        keycode = 16'h005B;
        repeat (2) @(negedge Clk);
        check("sel_frog2", sel_idx, 2);
        keycode = 16'h0000;
        repeat (2) @(negedge Clk);
        frog_alive = 3'b011;
        @(negedge Clk);
        check("dead_wrap_idx", sel_idx, 0);
        check("dead_wrap_onehot", sel_onehot, 3'b001);
        frog_alive = 3'b000;
        @(negedge Clk);
        check("none_alive_valid", sel_valid, 0);
        check("none_alive_onehot", sel_onehot, 0);
        check("none_alive_idx", sel_idx, 0);
        keycode = 16'h0052;
        frame_start();
        check("none_alive_nomove", dirs, 0);
        frame_end();
        keycode = 16'h0000;
        frog_alive = 3'b111;
        repeat (2) @(negedge Clk);
        idle_frame();

        // slot priority, then switch direction mid-DELAY
        keycode = 16'h5051;
        for (int f = 0; f < 3; f++) begin
            frame_start();
            check($sformatf("slot0_prio_f%0d", f), dirs, (f == 0) ? 4'b0010 : 4'b0000);
            frame_end();
        end
        keycode = 16'h0050;
        frame_start();
        check("switch_left", dirs, 4'b1000);
        frame_end();
        for (int f = 1; f <= 15; f++) begin
            frame_start();
            check($sformatf("reload_f%0d", f), dirs, (f == 15) ? 4'b1000 : 4'b0000);
            frame_end();
        end
        idle_frame();

        // game over clears the strobe on the next Clk and freezes everything
        keycode = 16'h0050;
        frame_start();
        check("go_pre_left", dirs, 4'b1000);
        game_over = 1'b1;
        @(negedge Clk);
        check("go_clear_next_clk", dirs, 0);
        frog_alive = 3'b110;
        frame_end();
        for (int f = 0; f < 20; f++) begin
            frame_start();
            check($sformatf("go_nomove_f%0d", f), dirs, 0);
            frame_end();
        end
        check("go_sel_frozen", sel_onehot, 3'b001);
        keycode = 16'h005A;
        repeat (3) @(negedge Clk);
        check("go_selkey_ignored", sel_idx, 0);
        keycode = 16'h0000;
        frog_alive = 3'b111;
        @(negedge Clk);
        game_over = 1'b0;
        idle_frame();

        // asynchronous reset while a strobe is high
        keycode = 16'h5A52;
        frame_start();
        check("pre_rst_up", dirs, 4'b0100);
        check("pre_rst_sel", sel_onehot, 3'b010);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_dirs", dirs, 0);
        check("async_rst_last", last_dir, 0);
        check("async_rst_onehot", sel_onehot, 3'b001);
        frame_clk = 1'b0;
        keycode = 16'h0000;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        idle_frame();

        // randomized run against a frame-level model
        m_active = 1'b0; m_held = '0; m_age = 0; m_last = '0; m_idx = 0; kc = '0;
        for (int f = 0; f < 150; f++) begin
            if (f == 0 || $urandom_range(0, 99) < 12)
                kc = {codes[$urandom_range(0, 8)], codes[$urandom_range(0, 8)]};
            keycode = kc;
            ksel = -1;
            if (kc[15:8] >= 8'h59 && kc[15:8] <= 8'h5B) ksel = int'(kc[15:8]) - 'h59;
            if (kc[7:0]  >= 8'h59 && kc[7:0]  <= 8'h5B) ksel = int'(kc[7:0])  - 'h59;
            if (ksel >= 0 && ksel != m_idx) begin
                m_idx    = ksel;
                m_active = 1'b0;
            end
            d = (m_dir(kc[7:0]) != 0) ? m_dir(kc[7:0]) : m_dir(kc[15:8]);
            exp_d = '0;
            if (!m_active) begin
                if (d != 0) begin
                    m_active = 1'b1; m_held = d; m_age = 0; exp_d = d;
                end
            end else if (d == 0) begin
                m_active = 1'b0;
            end else if (d != m_held) begin
                m_held = d; m_age = 0; exp_d = d;
            end else begin
                m_age++;
                if (m_age >= 15 && (m_age - 15) % 4 == 0) exp_d = d;
            end
            if (exp_d != 0) m_last = exp_d;
            frame_start();
            check($sformatf("rnd_dir_f%0d", f), dirs, exp_d);
            check($sformatf("rnd_last_f%0d", f), last_dir, m_last);
            check($sformatf("rnd_sel_f%0d", f), sel_onehot, 3'b001 << m_idx);
            frame_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
